// File: rtl/dp_pkg.sv
// Shared definitions for the ARM data-processing execute controller:
// opcode, shift-type and condition-code encodings, FSM states and
// small decode helpers.
package dp_pkg;

  // Data-processing opcodes, instr[24:21]
  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_EOR = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_RSB = 4'd3;
  localparam logic [3:0] OP_ADD = 4'd4;
  localparam logic [3:0] OP_ADC = 4'd5;
  localparam logic [3:0] OP_SBC = 4'd6;
  localparam logic [3:0] OP_RSC = 4'd7;
  localparam logic [3:0] OP_TST = 4'd8;
  localparam logic [3:0] OP_TEQ = 4'd9;
  localparam logic [3:0] OP_CMP = 4'd10;
  localparam logic [3:0] OP_CMN = 4'd11;
  localparam logic [3:0] OP_ORR = 4'd12;
  localparam logic [3:0] OP_MOV = 4'd13;
  localparam logic [3:0] OP_BIC = 4'd14;
  localparam logic [3:0] OP_MVN = 4'd15;

  // Shift types, instr[6:5]
  localparam logic [1:0] SH_LSL = 2'd0;
  localparam logic [1:0] SH_LSR = 2'd1;
  localparam logic [1:0] SH_ASR = 2'd2;
  localparam logic [1:0] SH_ROR = 2'd3;

  // Condition codes, instr[31:28]
  localparam logic [3:0] COND_EQ = 4'd0;
  localparam logic [3:0] COND_NE = 4'd1;
  localparam logic [3:0] COND_CS = 4'd2;
  localparam logic [3:0] COND_CC = 4'd3;
  localparam logic [3:0] COND_MI = 4'd4;
  localparam logic [3:0] COND_PL = 4'd5;
  localparam logic [3:0] COND_VS = 4'd6;
  localparam logic [3:0] COND_VC = 4'd7;
  localparam logic [3:0] COND_HI = 4'd8;
  localparam logic [3:0] COND_LS = 4'd9;
  localparam logic [3:0] COND_GE = 4'd10;
  localparam logic [3:0] COND_LT = 4'd11;
  localparam logic [3:0] COND_GT = 4'd12;
  localparam logic [3:0] COND_LE = 4'd13;
  localparam logic [3:0] COND_AL = 4'd14;
  localparam logic [3:0] COND_NV = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RS   = 2'd1,
    ST_EX   = 2'd2,
    ST_WB   = 2'd3
  } state_e;

  // Ops that only set flags and never write Rd.
  function automatic logic is_test_op(input logic [3:0] op);
    return (op == OP_TST) || (op == OP_TEQ) || (op == OP_CMP) || (op == OP_CMN);
  endfunction

  // Ops whose C flag comes from the shifter rather than the adder.
  function automatic logic is_logical_op(input logic [3:0] op);
    return (op == OP_AND) || (op == OP_EOR) || (op == OP_ORR) ||
           (op == OP_MOV) || (op == OP_BIC) || (op == OP_MVN);
  endfunction

  // Flag-only arithmetic ops: all four flags come straight from the ALU.
  function automatic logic is_compare_op(input logic [3:0] op);
    return (op == OP_CMP) || (op == OP_CMN);
  endfunction

  function automatic logic cond_passed(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    {n, z, c, v} = nzcv;
    case (cond)
      COND_EQ: return z;
      COND_NE: return !z;
      COND_CS: return c;
      COND_CC: return !c;
      COND_MI: return n;
      COND_PL: return !n;
      COND_VS: return v;
      COND_VC: return !v;
      COND_HI: return c && !z;
      COND_LS: return !c || z;
      COND_GE: return n == v;
      COND_LT: return n != v;
      COND_GT: return !z && (n == v);
      COND_LE: return z || (n != v);
      COND_AL: return 1'b1;
      COND_NV: return 1'b0;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dp_barrel_shifter.sv
// Combinational ARM shifter-operand unit. imm_form_i selects the
// instruction-field amount encoding, where #0 means LSR/ASR #32 or RRX;
// otherwise the amount follows register-shift semantics (0 = no shift).
module dp_barrel_shifter
  import dp_pkg::*;
(
  input  logic [31:0] value_i,
  input  logic [7:0]  amount_i,
  input  logic [1:0]  shift_type_i,
  input  logic        imm_form_i,
  input  logic        carry_in_i,
  output logic [31:0] result_o,
  output logic        carry_out_o
);

  logic [32:0] lsl_w;
  logic [32:0] lsr_w;
  logic [32:0] asr_w;
  logic [63:0] ror_w;

  // Shift with one guard bit so the last bit shifted out lands in the carry;
  // amounts of 32 and above fall out of the wide shifts naturally.
  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    result_o    = value_i;
    carry_out_o = carry_in_i;
    lsl_w       = {1'b0, value_i} << amount_i;
    lsr_w       = {value_i, 1'b0} >> amount_i;
    asr_w       = $signed({value_i, 1'b0}) >>> amount_i;
    ror_w       = {value_i, value_i} >> amount_i[4:0];

    if (imm_form_i && (amount_i[4:0] == 5'd0)) begin
      unique case (shift_type_i)
        SH_LSL: ;
        SH_LSR: begin
          result_o    = '0;
          carry_out_o = value_i[31];
        end
        SH_ASR: begin
          result_o    = {32{value_i[31]}};
          carry_out_o = value_i[31];
        end
        SH_ROR: begin
          result_o    = {carry_in_i, value_i[31:1]};
          carry_out_o = value_i[0];
        end
      endcase
    end else if (amount_i != 8'd0) begin
      unique case (shift_type_i)
        SH_LSL: {carry_out_o, result_o} = lsl_w;
        SH_LSR: {result_o, carry_out_o} = lsr_w;
        SH_ASR: {result_o, carry_out_o} = asr_w;
        SH_ROR: begin
          // A multiple-of-32 rotate leaves Rm intact and still reports Rm[31].
          result_o    = ror_w[31:0];
          carry_out_o = ror_w[31];
        end
      endcase
    end
  end

endmodule

// File: rtl/dp_exec_ctrl.sv
// Execute-stage issue/writeback controller for ARM data-processing
// instructions: decodes, reads Rn/Rm/Rs, forms the shifter operand,
// drives the ALU and writes Rd and CPSR flags.
// Optional build macro DP_PERF_CNT_EN adds perf_exec/perf_skip counters.
module dp_exec_ctrl
  import dp_pkg::*;
#(
  parameter int DW  = 32,
  parameter int RAW = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           instr_valid,
  output logic           instr_ready,
  input  logic [31:0]    instr,
  output logic [RAW-1:0] rf_raddr_a,
  output logic [RAW-1:0] rf_raddr_b,
  input  logic [DW-1:0]  rf_rdata_a,
  input  logic [DW-1:0]  rf_rdata_b,
  output logic [3:0]     alu_control,
  output logic [DW-1:0]  alu_operand_a,
  output logic [DW-1:0]  alu_operand_b,
  output logic           alu_carry_in,
  input  logic [DW-1:0]  alu_result,
  input  logic [3:0]     alu_nzcv,
  output logic           rf_we,
  output logic [RAW-1:0] rf_waddr,
  output logic [DW-1:0]  rf_wdata,
  output logic [3:0]     cpsr_nzcv,
  output logic           done,
  output logic           cond_fail,
  output logic           illegal
`ifdef DP_PERF_CNT_EN
  ,
  output logic [31:0]    perf_exec,
  output logic [31:0]    perf_skip
`endif
);

  state_e        state_q, state_d;
  logic [3:0]    cond_q;
  logic [25:0]   instr_q;      // instruction bits below the class field
  logic          illegal_q;
  logic [7:0]    rs_amt_q;
  logic [DW-1:0] res_q;
  logic [3:0]    alu_nzcv_q;
  logic [DW-1:0] sh_res_q;
  logic          sh_c_q;
  logic          pass_q;
  logic [3:0]    cpsr_q, cpsr_d;

  logic          accept;
  logic          dec_illegal;
  logic          dec_rs;
  logic [3:0]    op;
  logic          s_bit;
  logic          flags_upd;
  logic [DW-1:0] wb_data;

  logic [31:0]   sh_value;
  logic [7:0]    sh_amount;
  logic [1:0]    sh_type;
  logic          sh_imm_form;
  logic [31:0]   sh_res;
  logic          sh_c;

  assign accept      = instr_valid && (state_q == ST_IDLE);
  assign dec_illegal = (instr[27:26] != 2'b00) || (!instr[25] && (instr[7:4] == 4'b1001));
  assign dec_rs      = !instr[25] && instr[4];
  assign op          = instr_q[24:21];
  assign s_bit       = instr_q[20] || is_test_op(op);
  assign wb_data     = (op == OP_MOV) ? sh_res_q : res_q;
  assign flags_upd   = (state_q == ST_WB) && !illegal_q && pass_q && s_bit;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state: IDLE -> [RS] -> EX -> WB -> IDLE; illegal encodings skip to WB.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept) state_d = dec_illegal ? ST_WB : (dec_rs ? ST_RS : ST_EX);
      ST_RS:   state_d = ST_EX;
      ST_EX:   state_d = ST_WB;
      ST_WB:   state_d = ST_IDLE;
    endcase
  end

  // Shifter operand source: rotated imm8, Rm by immediate, or Rm by Rs[7:0].
  always_comb begin
    sh_value    = rf_rdata_b;
    sh_amount   = {3'b000, instr_q[11:7]};
    sh_type     = instr_q[6:5];
    sh_imm_form = 1'b1;
    if (instr_q[25]) begin
      sh_value    = {24'h0, instr_q[7:0]};
      sh_amount   = {3'b000, instr_q[11:8], 1'b0};
      sh_type     = SH_ROR;
      sh_imm_form = 1'b0;   // rot 0 must keep C, which is register-form behaviour
    end else if (instr_q[4]) begin
      sh_amount   = rs_amt_q;
      sh_imm_form = 1'b0;
    end
  end

  dp_barrel_shifter u_shifter (
    .value_i      (sh_value),
    .amount_i     (sh_amount),
    .shift_type_i (sh_type),
    .imm_form_i   (sh_imm_form),
    .carry_in_i   (cpsr_q[1]),
    .result_o     (sh_res),
    .carry_out_o  (sh_c)
  );

  // Datapath capture: instruction on accept, Rs amount in RS, ALU/shifter in EX.
  always_ff @(posedge clk) begin
    if (reset) begin
      cond_q     <= '0;
      instr_q    <= '0;
      illegal_q  <= 1'b0;
      rs_amt_q   <= '0;
      res_q      <= '0;
      alu_nzcv_q <= '0;
      sh_res_q   <= '0;
      sh_c_q     <= 1'b0;
      pass_q     <= 1'b0;
      cpsr_q     <= '0;
    end else begin
      if (accept) begin
        cond_q    <= instr[31:28];
        instr_q   <= instr[25:0];
        illegal_q <= dec_illegal;
      end
      if (state_q == ST_RS) rs_amt_q <= rf_rdata_a[7:0];
      if (state_q == ST_EX) begin
        res_q      <= alu_result;
        alu_nzcv_q <= alu_nzcv;
        sh_res_q   <= sh_res;
        sh_c_q     <= sh_c;
        pass_q     <= cond_passed(cond_q, cpsr_q);
      end
      cpsr_q <= cpsr_d;
    end
  end

  // CPSR update in WB, flag source depending on the op class.
  always_comb begin
    cpsr_d = cpsr_q;
    if (flags_upd) begin
      if (is_logical_op(op))
        cpsr_d = {wb_data[31], (wb_data == '0), sh_c_q, cpsr_q[0]};
      else if (is_compare_op(op))
        cpsr_d = alu_nzcv_q;
      else if (is_test_op(op))
        cpsr_d = {alu_nzcv_q[3:2], sh_c_q, cpsr_q[0]};
      else
        cpsr_d = {res_q[31], (res_q == '0), alu_nzcv_q[1:0]};
    end
  end

  // Outputs: register-file reads, ALU drive and writeback strobes per state.
  always_comb begin
    instr_ready   = (state_q == ST_IDLE);
    alu_control   = op;
    alu_carry_in  = cpsr_q[1];
    cpsr_nzcv     = cpsr_q;
    rf_raddr_a    = '0;
    rf_raddr_b    = '0;
    alu_operand_a = '0;
    alu_operand_b = '0;
    rf_we         = 1'b0;
    rf_waddr      = '0;
    rf_wdata      = '0;
    done          = 1'b0;
    cond_fail     = 1'b0;
    illegal       = 1'b0;
    unique case (state_q)
      ST_IDLE: ;
      ST_RS: rf_raddr_a = instr_q[11:8];
      ST_EX: begin
        rf_raddr_a    = instr_q[19:16];
        rf_raddr_b    = instr_q[3:0];
        alu_operand_a = ((op == OP_MOV) || (op == OP_MVN)) ? sh_res : rf_rdata_a;
        alu_operand_b = sh_res;
      end
      ST_WB: begin
        done      = 1'b1;
        illegal   = illegal_q;
        cond_fail = !illegal_q && !pass_q;
        rf_we     = !illegal_q && pass_q && !is_test_op(op);
        rf_waddr  = instr_q[15:12];
        rf_wdata  = wb_data;
      end
    endcase
  end

`ifdef DP_PERF_CNT_EN
  logic [31:0] perf_exec_q;
  logic [31:0] perf_skip_q;

  // Retired and condition-skipped instruction counters, wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_exec_q <= '0;
      perf_skip_q <= '0;
    end else begin
      if (done && !cond_fail && !illegal) perf_exec_q <= perf_exec_q + 32'd1;
      if (done && cond_fail)              perf_skip_q <= perf_skip_q + 32'd1;
    end
  end

  assign perf_exec = perf_exec_q;
  assign perf_skip = perf_skip_q;
`endif

endmodule

// File: tb/tb_dp_exec_ctrl.sv
// Directed bench for dp_exec_ctrl with a small register-file and ALU model.
module tb_dp_exec_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [3:0]  rf_raddr_a, rf_raddr_b;
  logic [31:0] rf_rdata_a, rf_rdata_b;
  logic [3:0]  alu_control;
  logic [31:0] alu_operand_a, alu_operand_b;
  logic        alu_carry_in;
  logic [31:0] alu_result;
  logic [3:0]  alu_nzcv;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [3:0]  cpsr_nzcv;
  logic        done, cond_fail, illegal;
`ifdef DP_PERF_CNT_EN
  logic [31:0] perf_exec, perf_skip;
`endif

  int checks = 0;
  int errors = 0;

  int          cap_lat;
  logic        cap_done, cap_we, cap_cf, cap_ill;
  logic [3:0]  cap_waddr;
  logic [31:0] cap_wdata;

  always #5 clk = ~clk;

  dp_exec_ctrl #(.DW(32), .RAW(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .rf_raddr_a    (rf_raddr_a),
    .rf_raddr_b    (rf_raddr_b),
    .rf_rdata_a    (rf_rdata_a),
    .rf_rdata_b    (rf_rdata_b),
    .alu_control   (alu_control),
    .alu_operand_a (alu_operand_a),
    .alu_operand_b (alu_operand_b),
    .alu_carry_in  (alu_carry_in),
    .alu_result    (alu_result),
    .alu_nzcv      (alu_nzcv),
    .rf_we         (rf_we),
    .rf_waddr      (rf_waddr),
    .rf_wdata      (rf_wdata),
    .cpsr_nzcv     (cpsr_nzcv),
    .done          (done),
    .cond_fail     (cond_fail),
    .illegal       (illegal)
`ifdef DP_PERF_CNT_EN
    ,
    .perf_exec     (perf_exec),
    .perf_skip     (perf_skip)
`endif
  );

  // Register file model, preloaded on reset.
  logic [31:0] regs [16];
  assign rf_rdata_a = regs[rf_raddr_a];
  assign rf_rdata_b = regs[rf_raddr_b];

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) regs[i] <= 32'h100 + i;
      regs[0] <= 32'd5;
      regs[2] <= 32'h22;
      regs[3] <= 32'd10;
      regs[4] <= 32'd20;
      regs[5] <= 32'h55;
      regs[6] <= 32'd1;
      regs[7] <= 32'd33;
    end else if (rf_we) begin
      regs[rf_waddr] <= rf_wdata;
    end
  end

  // ALU model: adder-based ops produce NZCV, logical ops produce N and Z.
  logic [31:0] ax, ay;
  logic        aci, arith;
  logic [32:0] asum;
  always_comb begin
    ax = alu_operand_a; ay = alu_operand_b; aci = 1'b0; arith = 1'b1;
    alu_result = '0; alu_nzcv = '0;
    case (alu_control)
      4'd2, 4'd10: begin ay = ~alu_operand_b; aci = 1'b1; end
      4'd3:        begin ax = alu_operand_b; ay = ~alu_operand_a; aci = 1'b1; end
      4'd4, 4'd11: ;
      4'd5:        aci = alu_carry_in;
      4'd6:        begin ay = ~alu_operand_b; aci = alu_carry_in; end
      4'd7:        begin ax = alu_operand_b; ay = ~alu_operand_a; aci = alu_carry_in; end
      default:     arith = 1'b0;
    endcase
    asum = {1'b0, ax} + {1'b0, ay} + {32'h0, aci};
    if (arith) begin
      alu_result = asum[31:0];
      alu_nzcv   = {asum[31], asum[31:0] == 32'h0, asum[32],
                    (ax[31] == ay[31]) && (asum[31] != ax[31])};
    end else begin
      case (alu_control)
        4'd0, 4'd8: alu_result = alu_operand_a & alu_operand_b;
        4'd1, 4'd9: alu_result = alu_operand_a ^ alu_operand_b;
        4'd12:      alu_result = alu_operand_a | alu_operand_b;
        4'd13:      alu_result = alu_operand_b;
        4'd14:      alu_result = alu_operand_a & ~alu_operand_b;
        default:    alu_result = ~alu_operand_b;
      endcase
      alu_nzcv = {alu_result[31], alu_result == 32'h0, 2'b00};
    end
  end

  task automatic do_reset();
    reset = 1'b1; instr_valid = 1'b0; instr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Offer one instruction, wait (bounded) for done, capture WB outputs,
  // then step one more cycle so CPSR and the register file are updated.
  task automatic run_instr(input logic [31:0] ins);
    @(negedge clk);
    instr_valid = 1'b1; instr = ins;
    @(posedge clk); #1;
    instr_valid = 1'b0; instr = 32'hFFFF_FFFF;
    cap_lat = 1;
    while (!done && cap_lat < 8) begin @(posedge clk); #1; cap_lat++; end
    cap_done = done; cap_we = rf_we; cap_waddr = rf_waddr; cap_wdata = rf_wdata;
    cap_cf = cond_fail; cap_ill = illegal;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b exp 1", instr_ready); end
    checks++; if ({rf_we, done, cond_fail, illegal} !== 4'b0000) begin errors++; $display("FAIL reset_strobes: got %b exp 0000", {rf_we, done, cond_fail, illegal}); end
    checks++; if (cpsr_nzcv !== 4'b0000) begin errors++; $display("FAIL reset_cpsr: got %b exp 0000", cpsr_nzcv); end
    checks++; if ({rf_waddr, rf_wdata, rf_raddr_a, rf_raddr_b} !== 44'h0) begin errors++; $display("FAIL reset_addr_data: got %h exp 0", {rf_waddr, rf_wdata, rf_raddr_a, rf_raddr_b}); end
  endtask

  task automatic test_mov_imm();
    run_instr(32'hE3B014FF);   // MOVS r1,#0xFF000000
    checks++; if (cap_lat !== 2 || cap_done !== 1'b1) begin errors++; $display("FAIL movs_imm_latency: got %0d exp 2", cap_lat); end
    checks++; if ({cap_we, cap_waddr, cap_wdata} !== {1'b1, 4'd1, 32'hFF000000}) begin errors++; $display("FAIL movs_imm_write: got we=%b rd=%0d data=%h exp we=1 rd=1 data=ff000000", cap_we, cap_waddr, cap_wdata); end
    checks++; if (cpsr_nzcv !== 4'b1010) begin errors++; $display("FAIL movs_imm_cpsr: got %b exp 1010", cpsr_nzcv); end
    checks++; if (regs[1] !== 32'hFF000000) begin errors++; $display("FAIL movs_imm_r1: got %h exp ff000000", regs[1]); end
  endtask

  task automatic test_cond_fail();
    run_instr(32'hE3B08000);   // MOVS r8,#0 -> Z=1, C kept at 1
    checks++; if (cpsr_nzcv !== 4'b0110) begin errors++; $display("FAIL movs_zero_cpsr: got %b exp 0110", cpsr_nzcv); end
    run_instr(32'h10832004);   // ADDNE r2,r3,r4
    checks++; if (cap_lat !== 2 || cap_cf !== 1'b1 || cap_we !== 1'b0) begin errors++; $display("FAIL addne_skip: got lat=%0d cf=%b we=%b exp lat=2 cf=1 we=0", cap_lat, cap_cf, cap_we); end
    checks++; if (cpsr_nzcv !== 4'b0110 || regs[2] !== 32'h22) begin errors++; $display("FAIL addne_no_effect: got cpsr=%b r2=%h exp 0110 22", cpsr_nzcv, regs[2]); end
  endtask

  task automatic test_compare();
    run_instr(32'hE3B094FF);   // MOVS r9,#0xFF000000 -> cpsr 1010
    checks++; if (cpsr_nzcv !== 4'b1010) begin errors++; $display("FAIL pre_cmp_cpsr: got %b exp 1010", cpsr_nzcv); end
    run_instr(32'hE1500000);   // CMP r0,r0
    checks++; if (cap_we !== 1'b0 || cap_cf !== 1'b0 || cap_done !== 1'b1) begin errors++; $display("FAIL cmp_strobes: got we=%b cf=%b done=%b exp 0 0 1", cap_we, cap_cf, cap_done); end
    checks++; if (cpsr_nzcv !== 4'b0110) begin errors++; $display("FAIL cmp_cpsr: got %b exp 0110", cpsr_nzcv); end
  endtask

  task automatic test_reg_shift();
    run_instr(32'hE1A05716);   // MOV r5,r6,LSL r7 (r7=33)
    checks++; if (cap_lat !== 3) begin errors++; $display("FAIL lsl_reg_latency: got %0d exp 3", cap_lat); end
    checks++; if ({cap_we, cap_waddr, cap_wdata} !== {1'b1, 4'd5, 32'h0}) begin errors++; $display("FAIL lsl33_write: got we=%b rd=%0d data=%h exp 1 5 0", cap_we, cap_waddr, cap_wdata); end
    checks++; if (cpsr_nzcv !== 4'b0110) begin errors++; $display("FAIL lsl33_cpsr: got %b exp 0110", cpsr_nzcv); end
    run_instr(32'hE3A07020);   // MOV r7,#32
    checks++; if (regs[7] !== 32'd32) begin errors++; $display("FAIL mov_r7: got %h exp 20", regs[7]); end
    run_instr(32'hE1500003);   // CMP r0,r3 -> 5-10: N=1 C=0
    checks++; if (cpsr_nzcv !== 4'b1000) begin errors++; $display("FAIL cmp_borrow_cpsr: got %b exp 1000", cpsr_nzcv); end
    run_instr(32'hE1B05716);   // MOVS r5,r6,LSL r7 (r7=32)
    checks++; if (cap_wdata !== 32'h0 || cap_we !== 1'b1) begin errors++; $display("FAIL lsl32_write: got we=%b data=%h exp 1 0", cap_we, cap_wdata); end
    checks++; if (cpsr_nzcv !== 4'b0110) begin errors++; $display("FAIL lsl32_cpsr: got %b exp 0110", cpsr_nzcv); end
  endtask

  task automatic test_imm_shifts();
    run_instr(32'hE093C221);   // ADDS r12,r3,r1,LSR #4
    checks++; if (cap_wdata !== 32'h0FF0000A || cap_waddr !== 4'd12) begin errors++; $display("FAIL adds_lsr4: got rd=%0d data=%h exp 12 0ff0000a", cap_waddr, cap_wdata); end
    checks++; if (cpsr_nzcv !== 4'b0000) begin errors++; $display("FAIL adds_lsr4_cpsr: got %b exp 0000", cpsr_nzcv); end
    run_instr(32'hE1B0A041);   // MOVS r10,r1,ASR #32
    checks++; if (cap_wdata !== 32'hFFFFFFFF) begin errors++; $display("FAIL asr32: got %h exp ffffffff", cap_wdata); end
    checks++; if (cpsr_nzcv !== 4'b1010) begin errors++; $display("FAIL asr32_cpsr: got %b exp 1010", cpsr_nzcv); end
    run_instr(32'hE1B0B066);   // MOVS r11,r6,RRX (C=1)
    checks++; if (cap_wdata !== 32'h80000000) begin errors++; $display("FAIL rrx: got %h exp 80000000", cap_wdata); end
    checks++; if (cpsr_nzcv !== 4'b1010) begin errors++; $display("FAIL rrx_cpsr: got %b exp 1010", cpsr_nzcv); end
  endtask

  task automatic test_illegal();
    run_instr(32'hE0000291);   // MUL encoding
    checks++; if (cap_lat !== 1 || cap_ill !== 1'b1) begin errors++; $display("FAIL mul_illegal: got lat=%0d ill=%b exp 1 1", cap_lat, cap_ill); end
    checks++; if (cap_we !== 1'b0 || cap_cf !== 1'b0 || cpsr_nzcv !== 4'b1010) begin errors++; $display("FAIL mul_no_effect: got we=%b cf=%b cpsr=%b exp 0 0 1010", cap_we, cap_cf, cpsr_nzcv); end
    run_instr(32'hE5912000);   // LDR encoding
    checks++; if (cap_ill !== 1'b1 || cap_we !== 1'b0) begin errors++; $display("FAIL ldr_illegal: got ill=%b we=%b exp 1 0", cap_ill, cap_we); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    instr_valid = 1'b1; instr = 32'hE3A0D001;   // MOV r13,#1
    @(posedge clk); #1;
    instr = 32'hE3A0E002;                        // MOV r14,#2, held valid
    checks++; if (instr_ready !== 1'b0) begin errors++; $display("FAIL busy_ready: got %b exp 0", instr_ready); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b1 || rf_waddr !== 4'd13 || rf_wdata !== 32'd1) begin errors++; $display("FAIL b2b_first: got done=%b rd=%0d data=%h exp 1 13 1", done, rf_waddr, rf_wdata); end
    @(posedge clk); #1;
    checks++; if (instr_ready !== 1'b1 || regs[13] !== 32'd1) begin errors++; $display("FAIL b2b_idle: got ready=%b r13=%h exp 1 1", instr_ready, regs[13]); end
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (done !== 1'b1 || rf_waddr !== 4'd14 || rf_wdata !== 32'd2) begin errors++; $display("FAIL b2b_second: got done=%b rd=%0d data=%h exp 1 14 2", done, rf_waddr, rf_wdata); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_abort();
    logic seen;
    @(negedge clk);
    instr_valid = 1'b1; instr = 32'hE0832004;   // ADD r2,r3,r4
    @(posedge clk); #1;
    instr_valid = 1'b0;
    reset = 1'b1;                                 // asserted during EX
    @(posedge clk); #1;
    checks++; if (rf_we !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL abort_strobes: got we=%b done=%b exp 0 0", rf_we, done); end
    checks++; if (cpsr_nzcv !== 4'b0000 || instr_ready !== 1'b1) begin errors++; $display("FAIL abort_state: got cpsr=%b ready=%b exp 0000 1", cpsr_nzcv, instr_ready); end
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    repeat (4) begin @(posedge clk); #1; if (done || rf_we) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL abort_late_done: got %b exp 0", seen); end
  endtask

`ifdef DP_PERF_CNT_EN
  task automatic test_perf();
    do_reset();
    #1;
    checks++; if (perf_exec !== 32'd0 || perf_skip !== 32'd0) begin errors++; $display("FAIL perf_reset: got %0d %0d exp 0 0", perf_exec, perf_skip); end
    run_instr(32'hE3A01001);
    run_instr(32'hF3A01001);
    run_instr(32'hE3A01001);
    run_instr(32'hE0000291);
    run_instr(32'hF3A01001);
    run_instr(32'hE3A01001);
    checks++; if (perf_exec !== 32'd3 || perf_skip !== 32'd2) begin errors++; $display("FAIL perf_counts: got exec=%0d skip=%0d exp 3 2", perf_exec, perf_skip); end
  endtask
`endif

  initial begin
    test_reset();
    test_mov_imm();
    test_cond_fail();
    test_compare();
    test_reg_shift();
    test_imm_shifts();
    test_illegal();
    test_back_to_back();
    test_reset_abort();
`ifdef DP_PERF_CNT_EN
    test_perf();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
